// File: rtl/ropuf_pkg.sv
// Shared types and constants for the RO-PUF measurement controller.
// The optional stability margin check is enabled by defining ROPUF_MARGIN_EN.
package ropuf_pkg;

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;
    localparam int unsigned TMR_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_COUNT,
        ST_SETTLE,
        ST_COMPARE,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic gt;
        logic tie;
        logic sat;
    } cmp_res_t;

    // Evaluate one oscillator pair: response bit, tie and saturation indications.
    function automatic cmp_res_t compare_pair(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
        cmp_res_t r;
        r.gt  = (a > b);
        r.tie = (a == b);
        r.sat = (a == CNT_SAT) || (b == CNT_SAT);
        return r;
    endfunction

endpackage

// File: rtl/ropuf_window_timer.sv
// Loadable down-counter timing the clear, count-window and settle phases.
// expire_c_o pulses for one cycle when a loaded count reaches zero.
module ropuf_window_timer
    import ropuf_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    output logic             expire_c_o
);

    logic [TMR_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (load_i) begin
            cnt_d = load_val_i;
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - TMR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    // Only a running count may expire, so an idle timer never pulses.
    assign expire_c_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/ropuf_measure_ctrl.sv
// RO-PUF measurement sequencer: clear, gated count, settle and compare per pair.
// Define ROPUF_MARGIN_EN to flag pairs whose count difference is below MARGIN.
module ropuf_measure_ctrl
    import ropuf_pkg::*;
#(
    parameter int unsigned N_BITS  = 64,
    parameter int unsigned SEL_W   = 7,
    parameter int unsigned WINDOW  = 4096,
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned CLR_CYC = 2,
    parameter int unsigned MARGIN  = 32
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              cnt_rst_o,
    output logic              ro_en_o,
    output logic [SEL_W-1:0]  sel_a_o,
    output logic [SEL_W-1:0]  sel_b_o,
    input  logic [CNT_W-1:0]  count_a_i,
    input  logic [CNT_W-1:0]  count_b_i,
    output logic [N_BITS-1:0] response_o,
    output logic              sat_flag_o,
    output logic              tie_flag_o,
    output logic [N_BITS-1:0] unstable_mask_o
);

    if (WINDOW < 1 || WINDOW > 65535 || SETTLE < 2 || SETTLE > 65536 ||
        CLR_CYC < 1 || CLR_CYC > 65536 || MARGIN > 65536 ||
        (1 << SEL_W) < (N_BITS + 1)) begin : g_param_err
        $error("ropuf_measure_ctrl: illegal parameter set");
    end

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  bit_idx_q, bit_idx_d;
    logic [SEL_W-1:0]  sel_b_q, sel_b_d;
    logic [N_BITS-1:0] response_q, response_d;
    logic              sat_q, sat_d;
    logic              tie_q, tie_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cnt_rst_q, cnt_rst_d;
    logic              ro_en_q, ro_en_d;
    logic              start_q;
    logic              start_rise;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_expire;
    cmp_res_t          res;

`ifdef ROPUF_MARGIN_EN
    logic [N_BITS-1:0] mask_q, mask_d;
    logic [CNT_W:0]    abs_diff;
    logic              unstable;

    // 17-bit magnitude of the count difference, so no wrap at the extremes.
    always_comb begin
        if (count_a_i >= count_b_i) begin
            abs_diff = {1'b0, count_a_i} - {1'b0, count_b_i};
        end else begin
            abs_diff = {1'b0, count_b_i} - {1'b0, count_a_i};
        end
        unstable = (abs_diff < (CNT_W + 1)'(MARGIN));
    end
`endif

    // Starts are edge-qualified so a level held across done cannot retrigger.
    assign start_rise = start_i && !start_q;
    assign res        = compare_pair(count_a_i, count_b_i);

    ropuf_window_timer u_timer (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_c_o (tmr_expire)
    );

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        response_d = response_q;
        sat_d      = sat_q;
        tie_d      = tie_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;
`ifdef ROPUF_MARGIN_EN
        mask_d     = mask_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d    = ST_CLEAR;
                    bit_idx_d  = '0;
                    response_d = '0;
                    sat_d      = 1'b0;
                    tie_d      = 1'b0;
                    busy_d     = 1'b1;
                    tmr_load   = 1'b1;
                    tmr_val    = TMR_W'(CLR_CYC - 1);
`ifdef ROPUF_MARGIN_EN
                    mask_d     = '0;
`endif
                end
            end
            ST_CLEAR: begin
                if (tmr_expire) begin
                    state_d  = ST_COUNT;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(WINDOW - 1);
                end
            end
            ST_COUNT: begin
                if (tmr_expire) begin
                    state_d  = ST_SETTLE;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(SETTLE - 1);
                end
            end
            ST_SETTLE: begin
                if (tmr_expire) begin
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                sat_d = sat_q | res.sat;
                tie_d = tie_q | res.tie;
                for (int unsigned i = 0; i < N_BITS; i++) begin
                    if (bit_idx_q == SEL_W'(i)) begin
                        response_d[i] = res.gt;
`ifdef ROPUF_MARGIN_EN
                        mask_d[i]     = unstable;
`endif
                    end
                end
                if (bit_idx_q == SEL_W'(N_BITS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d   = ST_CLEAR;
                    bit_idx_d = bit_idx_q + SEL_W'(1);
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(CLR_CYC - 1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        sel_b_d   = bit_idx_d + SEL_W'(1);
        cnt_rst_d = (state_d == ST_CLEAR);
        ro_en_d   = (state_d == ST_COUNT);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            bit_idx_q  <= '0;
            sel_b_q    <= '0;
            response_q <= '0;
            sat_q      <= 1'b0;
            tie_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_rst_q  <= 1'b0;
            ro_en_q    <= 1'b0;
            start_q    <= 1'b0;
`ifdef ROPUF_MARGIN_EN
            mask_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            sel_b_q    <= sel_b_d;
            response_q <= response_d;
            sat_q      <= sat_d;
            tie_q      <= tie_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cnt_rst_q  <= cnt_rst_d;
            ro_en_q    <= ro_en_d;
            start_q    <= start_i;
`ifdef ROPUF_MARGIN_EN
            mask_q     <= mask_d;
`endif
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign cnt_rst_o  = cnt_rst_q;
    assign ro_en_o    = ro_en_q;
    assign sel_a_o    = bit_idx_q;
    assign sel_b_o    = sel_b_q;
    assign response_o = response_q;
    assign sat_flag_o = sat_q;
    assign tie_flag_o = tie_q;

`ifdef ROPUF_MARGIN_EN
    assign unstable_mask_o = mask_q;
`else
    assign unstable_mask_o = '0;
`endif

endmodule

// File: tb/tb_ropuf_measure_ctrl.sv
// Scoreboard bench for ropuf_measure_ctrl with a behavioural counter-array model.
// Honours ROPUF_MARGIN_EN in the reference model when the macro is defined.
module tb_ropuf_measure_ctrl;

    localparam int unsigned N       = 4;
    localparam int unsigned SW      = 3;
    localparam int unsigned WIN     = 16;
    localparam int unsigned SET     = 4;
    localparam int unsigned CLR     = 2;
    localparam int unsigned MARG    = 32;
    localparam int          LAT     = N * (CLR + WIN + SET + 1) + 1;

    typedef struct {
        logic [N-1:0] resp;
        logic         sat;
        logic         tie;
        logic [N-1:0] mask;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, cnt_rst, ro_en, sat_flag, tie_flag;
    logic [SW-1:0] sel_a, sel_b;
    logic [15:0]   count_a, count_b;
    logic [N-1:0]  response, umask;

    logic [15:0] tab_a [8];
    logic [15:0] tab_b [8];
    logic [15:0] junk_a, junk_b;
    int          win_cyc, post_cyc, cyc, t0;
    int          tests = 0;
    int          fails = 0;
    exp_t        exp_q[$];

    ropuf_measure_ctrl #(
        .N_BITS(N), .SEL_W(SW), .WINDOW(WIN), .SETTLE(SET), .CLR_CYC(CLR), .MARGIN(MARG)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .start_i         (start),
        .busy_o          (busy),
        .done_o          (done),
        .cnt_rst_o       (cnt_rst),
        .ro_en_o         (ro_en),
        .sel_a_o         (sel_a),
        .sel_b_o         (sel_b),
        .count_a_i       (count_a),
        .count_b_i       (count_b),
        .response_o      (response),
        .sat_flag_o      (sat_flag),
        .tie_flag_o      (tie_flag),
        .unstable_mask_o (umask)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Counter-array model: counts are only trustworthy after a full window and settling.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_cyc  <= 0;
            post_cyc <= 0;
        end else begin
            junk_a <= 16'($urandom);
            junk_b <= 16'($urandom);
            if (cnt_rst) begin
                win_cyc  <= 0;
                post_cyc <= 0;
            end else if (ro_en) begin
                win_cyc  <= win_cyc + 1;
                post_cyc <= 0;
            end else begin
                post_cyc <= post_cyc + 1;
            end
        end
    end

    always_comb begin
        if (win_cyc == WIN && post_cyc >= SET && !ro_en && !cnt_rst) begin
            count_a = tab_a[sel_a];
            count_b = tab_b[sel_a];
        end else begin
            count_a = junk_a;
            count_b = junk_b;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t model();
        exp_t e;
        int   d;
        e.resp = '0;
        e.mask = '0;
        e.sat  = 1'b0;
        e.tie  = 1'b0;
        for (int i = 0; i < N; i++) begin
            e.resp[i] = (int'(tab_a[i]) > int'(tab_b[i]));
            if (tab_a[i] == tab_b[i]) e.tie = 1'b1;
            if (tab_a[i] == 16'hFFFF || tab_b[i] == 16'hFFFF) e.sat = 1'b1;
            d = int'(tab_a[i]) - int'(tab_b[i]);
            if (d < 0) d = -d;
`ifdef ROPUF_MARGIN_EN
            e.mask[i] = (d < MARG);
`else
            e.mask[i] = 1'b0;
`endif
        end
        return e;
    endfunction

    // Monitor: phase statistics per run, scored against the queue head on done.
    initial begin : monitor
        int          ro_cnt, clr_cnt, sel_bad;
        logic        prev_ro;
        logic [SW-1:0] seen_a[$];
        logic [SW-1:0] seen_b[$];
        exp_t        e;
        ro_cnt = 0; clr_cnt = 0; sel_bad = 0; prev_ro = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                ro_cnt = 0; clr_cnt = 0; sel_bad = 0; prev_ro = 1'b0;
                seen_a.delete(); seen_b.delete();
            end else begin
                if (ro_en) ro_cnt++;
                if (cnt_rst) clr_cnt++;
                if (ro_en && !prev_ro) begin
                    seen_a.push_back(sel_a);
                    seen_b.push_back(sel_b);
                end
                if (busy && (int'(sel_b) != int'(sel_a) + 1)) sel_bad++;
                prev_ro = ro_en;
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("response", 64'(response), 64'(e.resp));
                        chk("sat_flag", 64'(sat_flag), 64'(e.sat));
                        chk("tie_flag", 64'(tie_flag), 64'(e.tie));
                        chk("unstable_mask", 64'(umask), 64'(e.mask));
                        chk("busy_at_done", 64'(busy), 64'd0);
                        chk("latency", 64'(cyc - t0), 64'(LAT));
                        chk("ro_en_cycles", 64'(ro_cnt), 64'(N * WIN));
                        chk("cnt_rst_cycles", 64'(clr_cnt), 64'(N * CLR));
                        chk("sel_pair_step", 64'(sel_bad), 64'd0);
                        chk("sel_windows", 64'(seen_a.size()), 64'(N));
                        for (int i = 0; i < N && i < seen_a.size(); i++) begin
                            chk("sel_a_seq", 64'(seen_a[i]), 64'(i));
                            chk("sel_b_seq", 64'(seen_b[i]), 64'(i + 1));
                        end
                    end
                    ro_cnt = 0; clr_cnt = 0; sel_bad = 0;
                    seen_a.delete(); seen_b.delete();
                end
            end
        end
    end

    task automatic issue_run();
        exp_q.push_back(model());
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t0 = cyc;
    endtask

    // mode 0: quiet, 1: stray start pulses while busy, 2: start held high across done
    task automatic wait_done(input int mode);
        bit seen = 0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1;
            if (mode == 1 && (k == 20 || k == 60)) start = 1'b1;
            if (mode == 1 && (k == 21 || k == 61)) start = 1'b0;
            if (mode == 2 && k == 85) start = 1'b1;
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    task automatic fill(input logic [15:0] a0, b0, a1, b1, a2, b2, a3, b3);
        tab_a[0] = a0; tab_b[0] = b0; tab_a[1] = a1; tab_b[1] = b1;
        tab_a[2] = a2; tab_b[2] = b2; tab_a[3] = a3; tab_b[3] = b3;
    endtask

    task automatic fill_random();
        int m;
        for (int i = 0; i < N; i++) begin
            m = int'($urandom_range(0, 5));
            tab_a[i] = 16'($urandom);
            case (m)
                0: tab_b[i] = tab_a[i];
                1: begin tab_a[i] = 16'hFFFF; tab_b[i] = 16'($urandom); end
                2: tab_b[i] = 16'hFFFF;
                3: tab_b[i] = 16'(int'(tab_a[i] & 16'h7FFF) + int'($urandom_range(0, 40)));
                default: tab_b[i] = 16'($urandom);
            endcase
        end
    endtask

    initial begin : stim
        int bcnt, dcnt;
        bit hit;
        for (int i = 0; i < 8; i++) begin tab_a[i] = '0; tab_b[i] = '0; end
        cyc = 0; t0 = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ro_en", 64'(ro_en), 64'd0);
        chk("rst_cnt_rst", 64'(cnt_rst), 64'd0);
        chk("rst_sel_b", 64'(sel_b), 64'd0);
        chk("rst_response", 64'(response), 64'd0);
        chk("rst_flags", 64'({sat_flag, tie_flag, done}), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        fill(100, 90, 100, 90, 100, 90, 100, 90);
        issue_run(); wait_done(0);
        fill(50, 60, 60, 50, 50, 60, 60, 50);
        issue_run(); wait_done(1);
        fill(10, 5, 16'hFFFF, 3, 777, 777, 2, 9);
        issue_run(); wait_done(0);
        fill(1031, 1000, 1000, 1032, 400, 400, 900, 400);
        issue_run(); wait_done(2);

        // start still high after done: no new run without a fresh edge
        bcnt = 0; dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) dcnt++;
        end
        chk("held_start_busy", 64'(bcnt), 64'd0);
        chk("held_start_done", 64'(dcnt), 64'd0);
        chk("hold_response", 64'(response), 64'(model().resp));
        start = 1'b0;
        repeat (2) @(negedge clk);

        // asynchronous reset during the window of bit 1
        fill(300, 100, 200, 100, 50, 40, 10, 20);
        issue_run();
        hit = 0;
        for (int k = 0; k < 300 && !hit; k++) begin
            @(negedge clk);
            if (sel_a == SW'(1) && ro_en) hit = 1;
        end
        chk("reach_bit1_count", 64'(hit), 64'd1);
        chk("pre_rst_response", 64'(response[0]), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_ro_en", 64'(ro_en), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_response", 64'(response), 64'd0);
        void'(exp_q.pop_back());
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        issue_run(); wait_done(0);

        for (int r = 0; r < 6; r++) begin
            fill_random();
            issue_run(); wait_done(r % 2);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
